panel_scan: RTL and testbench
=============================

// Module: panel_scan
// PURPOSE
//  Physical-panel end of the PDP-1 front-panel interface: scans a multiplexed LED/switch matrix.
//  Displays the three 18-bit light words and returns two debounced 18-bit switch words.
//  Its sw0/sw1 outputs feed the panel logic's switch inputs; its light inputs come from that logic's light outputs.
//  Five-slot time-multiplexed scan: L0, L1, L2, S0, S1, repeating.
// PARAMETERS
//  DWELL      1000  cycles a row is driven per slot (>=2)
//  BLANK      16    all-rows-off cycles before each dwell, for anti-ghosting (>=1)
//  DEB_SCANS  4     consecutive identical frame samples needed to commit a switch row (>=1)
// PORTS
//  clk      in   1     sole clock
//  reset_n  in   1     asynchronous, active-low reset
//  light0   in   [0:17] light row 0 word
//  light1   in   [0:17] light row 1 word
//  light2   in   [0:17] light row 2 word
//  sw0      out  [0:17] debounced switch row 0, 1 = closed
//  sw1      out  [0:17] debounced switch row 1, 1 = closed
//  row_n    out  [0:4]  active-low row drives; 0-2 = light rows, 3-4 = switch rows
//  col      out  [0:17] LED column data, valid while col_oe=1
//  col_oe   out  1      column drivers enabled (light-slot dwell only)
//  col_in   in   [0:17] switch column sense; active-low with pull-ups, 0 = closed
//  frame    out  1      one-cycle pulse on each wrap from S1 to L0
// BEHAVIOUR
//  Reset (async assert, sync release) forces:
//   - sw0 = sw1 = 0, row_n = 5'b11111, col = 0, col_oe = 0, frame = 0
//   - slot = L0, phase = BLANK, counter = 0, debounce state cleared
//  Slot timing:
//   - each slot is BLANK cycles of BLANK phase, then DWELL cycles of DWELL phase
//   - frame = 5*(BLANK+DWELL) cycles
//   - first reset-released cycle is L0 BLANK, count 0
//  BLANK phase:
//   - row_n all 1, col_oe = 0, col = 0
//  Light slot Lk:
//   - on the last BLANK cycle, snapshot lightk into the column register
//   - during DWELL: row_n[k] = 0, col_oe = 1, col = snapshot
//   - input changes during a dwell are not shown until that row's next slot (no tearing)
//  Switch slot Sj:
//   - during DWELL: row_n[3+j] = 0, col_oe = 0
//   - col_in passes through a 2-flop synchronizer and is inverted
//   - sample = synchronized value on the last DWELL cycle
//  Debounce, per switch row:
//   - sample == prev: cnt++, saturating at DEB_SCANS
//   - sample != prev: prev <= sample, cnt <= 1
//   - when cnt reaches DEB_SCANS, swj <= prev
//   - all updates on the same edge as the sample; swj is visible the next cycle
//   - DEB_SCANS=1: every sample commits immediately
//   - swj changes only on that edge, never mid-slot
//  frame: asserted during the first cycle of L0 BLANK after S1 completes.
//   - not asserted in the first frame after reset
//  Wrap: the slot counter wraps S1 -> L0; the phase counter is sized for max(BLANK, DWELL).
//  Reset mid-dwell: rows turn off immediately, combinationally via the async clear of the row register.
//   - the in-progress sample is discarded
//  Never more than one row_n bit low; BLANK separates every row change.
// STRUCTURE
//  Shared package pdp1panel_pkg:
//   - slot encoding (L0..S1), NSLOTS = 5, WORD = 18
//   - light/switch row counts
//  Sub-module panel_debounce: one per switch row, holding the prev/cnt/commit logic.
//   - ports: clk, reset_n, strobe, sample[0:17], q[0:17]
//  Top level holds the synchronizer, slot/phase counters, row decode and the column snapshot register.
// TESTING (DWELL=4, BLANK=2, DEB_SCANS=3; frame = 30 cycles)
//  1. Reset then release -> all reset values; cycles 0-1 row_n=11111; cycles 2-5 row_n=01111, col_oe=1.
//  2. light0=18'o252525, light1=18'o777777, light2=0 -> col=o252525 in L0 dwell, o777777 in L1, 0 in L2.
//     -> col=0 in all blanks; frame pulses at cycles 30, 60, ...
//  3. col_in held 18'o777776 (bit17 closed) -> sw0=18'o000001, and also sw1 (col_in is held constant),
//     -> one cycle after the 3rd S0/S1 sample; earlier frames keep 0.
//  4. col_in bit0 toggled once per frame, sampled alternately closed/open -> sw0/sw1 stay 0 indefinitely.
//  5. light0 changed from o1 to o2 at cycle 3 (mid L0 dwell) -> col=o1 through cycle 5; o2 at next frame's L0.
//  6. reset_n dropped at cycle 2+30*n+1 mid dwell -> row_n=11111 and col_oe=0 the same cycle, sw0/sw1=0.
//     -> after release, restart at L0 BLANK.

Source files
------------

// File: rtl/pdp1panel_pkg.sv
// Shared definitions for the PDP-1 front-panel scanner: word size, row counts,
// slot and phase encodings, and the slot sequencing helper.
package pdp1panel_pkg;

   localparam int WORD    = 18;
   localparam int NSLOTS  = 5;
   localparam int NLIGHT  = 3;
   localparam int NSWITCH = 2;

   typedef enum logic [2:0] {
      SLOT_L0 = 3'd0,
      SLOT_L1 = 3'd1,
      SLOT_L2 = 3'd2,
      SLOT_S0 = 3'd3,
      SLOT_S1 = 3'd4
   } slot_e;

   typedef enum logic {
      PH_BLANK = 1'b0,
      PH_DWELL = 1'b1
   } phase_e;

   function automatic slot_e next_slot(input slot_e s);
      slot_e n;
      case (s)
         SLOT_L0: n = SLOT_L1;
         SLOT_L1: n = SLOT_L2;
         SLOT_L2: n = SLOT_S0;
         SLOT_S0: n = SLOT_S1;
         SLOT_S1: n = SLOT_L0;
         default: n = SLOT_L0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/panel_debounce.sv
// Per-row switch debouncer: a row word is committed once the same sample has
// been seen on DEB_SCANS consecutive strobes.
module panel_debounce
   import pdp1panel_pkg::*;
#(
   parameter int DEB_SCANS = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            strobe,
   input  logic [0:WORD-1] sample,
   output logic [0:WORD-1] q
);

   localparam int CW = $clog2(DEB_SCANS + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_SCANS);

   logic [0:WORD-1] prev_q, prev_d;
   logic [0:WORD-1] q_q, q_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   always_comb begin
      prev_d = prev_q;
      cnt_d  = cnt_q;
      q_d    = q_q;
      if (strobe) begin
         if (sample == prev_q) begin
            if (cnt_q == CNT_MAX) begin
               cnt_d = cnt_q;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end else begin
            prev_d = sample;
            cnt_d  = CW'(1);
         end
         // Commit on the same edge the run length is reached.
         if (cnt_d == CNT_MAX) begin
            q_d = prev_d;
         end else begin
            q_d = q_q;
         end
      end else begin
         q_d = q_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_q <= '0;
         cnt_q  <= '0;
         q_q    <= '0;
      end else begin
         prev_q <= prev_d;
         cnt_q  <= cnt_d;
         q_q    <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/panel_scan.sv
// Multiplexed LED/switch matrix scanner: cycles L0, L1, L2, S0, S1 with a blank
// gap before every dwell, drives light columns and debounces switch rows.
module panel_scan
   import pdp1panel_pkg::*;
#(
   parameter int DWELL     = 1000,
   parameter int BLANK     = 16,
   parameter int DEB_SCANS = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [0:WORD-1] light0,
   input  logic [0:WORD-1] light1,
   input  logic [0:WORD-1] light2,
   output logic [0:WORD-1] sw0,
   output logic [0:WORD-1] sw1,
   output logic [0:4]      row_n,
   output logic [0:WORD-1] col,
   output logic            col_oe,
   input  logic [0:WORD-1] col_in,
   output logic            frame
);

   localparam int MAXP = (BLANK > DWELL) ? BLANK : DWELL;
   localparam int CW   = (MAXP > 1) ? $clog2(MAXP) : 1;
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

   slot_e           slot_q, slot_d;
   phase_e          phase_q, phase_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [0:4]      row_n_q, row_n_d;
   logic [0:WORD-1] col_q, col_d;
   logic            col_oe_q, col_oe_d;
   logic            frame_q, frame_d;
   logic [0:WORD-1] sync1_q, sync2_q;
   logic            strobe0_s, strobe1_s;
   logic [0:WORD-1] sample_s;

   // Switch columns idle high through pull-ups; invert so 1 means closed.
   assign sample_s = ~sync2_q;

   // Slot/phase sequencing; row, column and frame outputs are decoded from the
   // next state so the registered outputs line up with the current state.
   always_comb begin
      slot_d    = slot_q;
      phase_d   = phase_q;
      cnt_d     = cnt_q + CW'(1);
      frame_d   = 1'b0;
      strobe0_s = 1'b0;
      strobe1_s = 1'b0;
      row_n_d   = 5'b11111;
      col_oe_d  = 1'b0;
      col_d     = '0;

      if (phase_q == PH_BLANK) begin
         if (cnt_q == BLANK_LAST) begin
            phase_d = PH_DWELL;
            cnt_d   = '0;
         end else begin
            phase_d = PH_BLANK;
         end
      end else begin
         if (cnt_q == DWELL_LAST) begin
            phase_d   = PH_BLANK;
            cnt_d     = '0;
            slot_d    = next_slot(slot_q);
            frame_d   = (slot_q == SLOT_S1);
            strobe0_s = (slot_q == SLOT_S0);
            strobe1_s = (slot_q == SLOT_S1);
         end else begin
            phase_d = PH_DWELL;
         end
      end

      // The light word is captured only when a dwell starts, so it cannot tear.
      if (phase_d == PH_DWELL) begin
         case (slot_d)
            SLOT_L0: begin
               row_n_d[0] = 1'b0;
               col_oe_d   = 1'b1;
               col_d      = (phase_q == PH_BLANK) ? light0 : col_q;
            end
            SLOT_L1: begin
               row_n_d[1] = 1'b0;
               col_oe_d   = 1'b1;
               col_d      = (phase_q == PH_BLANK) ? light1 : col_q;
            end
            SLOT_L2: begin
               row_n_d[2] = 1'b0;
               col_oe_d   = 1'b1;
               col_d      = (phase_q == PH_BLANK) ? light2 : col_q;
            end
            SLOT_S0: row_n_d[3] = 1'b0;
            SLOT_S1: row_n_d[4] = 1'b0;
            default: row_n_d = 5'b11111;
         endcase
      end else begin
         row_n_d = 5'b11111;
      end
   end

   // Scan state and registered panel drives; async clear turns all rows off at once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         slot_q   <= SLOT_L0;
         phase_q  <= PH_BLANK;
         cnt_q    <= '0;
         row_n_q  <= 5'b11111;
         col_q    <= '0;
         col_oe_q <= 1'b0;
         frame_q  <= 1'b0;
      end else begin
         slot_q   <= slot_d;
         phase_q  <= phase_d;
         cnt_q    <= cnt_d;
         row_n_q  <= row_n_d;
         col_q    <= col_d;
         col_oe_q <= col_oe_d;
         frame_q  <= frame_d;
      end
   end

   // Two-flop synchronizer for the asynchronous switch sense lines.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= col_in;
         sync2_q <= sync1_q;
      end
   end

   panel_debounce #(.DEB_SCANS(DEB_SCANS)) u_deb0 (
      .clk     (clk),
      .reset_n (reset_n),
      .strobe  (strobe0_s),
      .sample  (sample_s),
      .q       (sw0)
   );

   panel_debounce #(.DEB_SCANS(DEB_SCANS)) u_deb1 (
      .clk     (clk),
      .reset_n (reset_n),
      .strobe  (strobe1_s),
      .sample  (sample_s),
      .q       (sw1)
   );

   assign row_n  = row_n_q;
   assign col    = col_q;
   assign col_oe = col_oe_q;
   assign frame  = frame_q;

endmodule

// File: tb/tb_panel_scan.sv
// Scoreboard bench for panel_scan: a cycle-indexed panel model pushes expected
// outputs per cycle and a negedge monitor pops and compares them.
module tb_panel_scan;

   localparam int DWELL     = 4;
   localparam int BLANK     = 2;
   localparam int DEB       = 3;
   localparam int SLOT_LEN  = BLANK + DWELL;
   localparam int FRAME_LEN = 5 * SLOT_LEN;

   typedef struct {
      int         t;
      logic [0:4] row_n;
      logic [0:17] col;
      logic       col_oe;
      logic       frame;
      logic [0:17] sw0;
      logic [0:17] sw1;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [0:17] light0, light1, light2, col_in;
   logic [0:17] sw0, sw1, col;
   logic [0:4]  row_n;
   logic        col_oe, frame;

   exp_t        sb_q[$];
   exp_t        mon_e;
   int          n_cmp = 0;
   int          n_bad = 0;

   int          t;
   logic [0:17] snap [0:7];
   logic [0:17] c1, c2;
   logic [0:17] prev [0:1];
   int          cnt  [0:1];
   logic [0:17] swm  [0:1];

   always #5 clk = ~clk;

   panel_scan #(.DWELL(DWELL), .BLANK(BLANK), .DEB_SCANS(DEB)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .light0  (light0),
      .light1  (light1),
      .light2  (light2),
      .sw0     (sw0),
      .sw1     (sw1),
      .row_n   (row_n),
      .col     (col),
      .col_oe  (col_oe),
      .col_in  (col_in),
      .frame   (frame)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0o expected %0o at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      t = 0;
      for (int i = 0; i < 8; i++) snap[i] = '0;
      c1 = '1;
      c2 = '1;
      for (int j = 0; j < 2; j++) begin
         prev[j] = '0;
         cnt[j]  = 0;
         swm[j]  = '0;
      end
   endtask

   function automatic exp_t model_expect();
      exp_t       e;
      logic [2:0] pos;
      logic [2:0] slot;
      pos  = 3'(t % SLOT_LEN);
      slot = 3'((t / SLOT_LEN) % 5);
      e.t      = t;
      e.row_n  = 5'b11111;
      if (int'(pos) >= BLANK) e.row_n[slot] = 1'b0;
      e.col_oe = (int'(pos) >= BLANK) && (slot < 3'd3);
      e.col    = e.col_oe ? snap[slot] : 18'o0;
      e.frame  = (t > 0) && (t % FRAME_LEN == 0);
      e.sw0    = swm[0];
      e.sw1    = swm[1];
      return e;
   endfunction

   // End-of-cycle model update using the inputs held during cycle t.
   task automatic model_update();
      logic [2:0]  pos;
      logic [2:0]  slot;
      logic        j;
      logic [0:17] s;
      pos  = 3'(t % SLOT_LEN);
      slot = 3'((t / SLOT_LEN) % 5);
      if (int'(pos) == BLANK - 1) begin
         case (slot)
            3'd0:    snap[0] = light0;
            3'd1:    snap[1] = light1;
            3'd2:    snap[2] = light2;
            default: ;
         endcase
      end
      if (int'(pos) == SLOT_LEN - 1 && slot >= 3'd3) begin
         j = (slot == 3'd4);
         s = ~c2;
         if (s == prev[j]) begin
            if (cnt[j] < DEB) cnt[j]++;
         end else begin
            prev[j] = s;
            cnt[j]  = 1;
         end
         if (cnt[j] == DEB) swm[j] = prev[j];
      end
      c2 = c1;
      c1 = col_in;
      t++;
   endtask

   task automatic step();
      sb_q.push_back(model_expect());
      @(posedge clk);
      model_update();
      #1;
   endtask

   always @(negedge clk) begin
      if (sb_q.size() != 0) begin
         mon_e = sb_q.pop_front();
         check_val($sformatf("row_n@%0d", mon_e.t), 32'(row_n), 32'(mon_e.row_n));
         check_val($sformatf("col@%0d", mon_e.t), 32'(col), 32'(mon_e.col));
         check_val($sformatf("col_oe@%0d", mon_e.t), 32'(col_oe), 32'(mon_e.col_oe));
         check_val($sformatf("frame@%0d", mon_e.t), 32'(frame), 32'(mon_e.frame));
         check_val($sformatf("sw0@%0d", mon_e.t), 32'(sw0), 32'(mon_e.sw0));
         check_val($sformatf("sw1@%0d", mon_e.t), 32'(sw1), 32'(mon_e.sw1));
      end
   end

   task automatic check_reset_state(input string tag);
      check_val({tag, "_row_n"}, 32'(row_n), 32'h1f);
      check_val({tag, "_col"}, 32'(col), 32'h0);
      check_val({tag, "_col_oe"}, 32'(col_oe), 32'h0);
      check_val({tag, "_frame"}, 32'(frame), 32'h0);
      check_val({tag, "_sw0"}, 32'(sw0), 32'h0);
      check_val({tag, "_sw1"}, 32'(sw1), 32'h0);
   endtask

   initial begin
      reset_n = 1'b0;
      light0  = 18'o0;
      light1  = 18'o0;
      light2  = 18'o0;
      col_in  = 18'o777777;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("reset");

      // Patterned lights, switch column 17 held closed.
      light0  = 18'o252525;
      light1  = 18'o777777;
      light2  = 18'o000000;
      col_in  = 18'o777776;
      reset_n = 1'b1;
      for (int i = 0; i < 3 * FRAME_LEN + 3; i++) step();

      // Mid-dwell reset of L0 (cycle 93): rows must drop within the same cycle.
      check_val("pre_reset_sw0", 32'(sw0), 32'o1);
      reset_n = 1'b0;
      #1;
      check_reset_state("mid_reset");
      repeat (2) @(posedge clk);
      #1;
      model_reset();

      // Light word changed mid-dwell; switch bit0 toggled every frame.
      light0  = 18'o000001;
      light1  = 18'o000003;
      light2  = 18'o000004;
      col_in  = 18'o377776;
      reset_n = 1'b1;
      for (int i = 0; i < 4 * FRAME_LEN; i++) begin
         if (t == 3) light0 = 18'o000002;
         col_in = ((t / FRAME_LEN) % 2 == 0) ? 18'o377776 : 18'o777776;
         step();
      end
      check_val("toggle_sw0", 32'(sw0), 32'h0);
      check_val("toggle_sw1", 32'(sw1), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
